// File: rtl/mul_join_pkg.sv
// rtl/mul_join_pkg.sv - shared types and helpers for the operand join stage
package mul_join_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } slot_state_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/join_fifo.sv
// rtl/join_fifo.sv - per-operand FIFO with registered ready and occupancy count
module join_fifo
  import mul_join_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    ready_o,
  output logic [ptr_w(DEPTH):0]   count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             push_ok, pop_ok;

  // ready_q is the registered not-full flag, so a full FIFO refuses a push
  // even when a pop frees a slot in the same cycle.
  assign push_ok = push_i & ready_q;
  assign pop_ok  = pop_i & (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/mul_operand_join.sv
// rtl/mul_operand_join.sv - pairs buffered A/B operand streams into one valid slot
// Optional statistics ports (pair_count, skew_max) exist when JOIN_STATS_EN is defined.
module mul_operand_join
  import mul_join_pkg::*;
#(
  parameter int DATAWIDTH_IN_A = 32,
  parameter int DATAWIDTH_IN_B = 32,
  parameter int DEPTH          = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_a_tvalid,
  output logic                      s_axis_a_tready,
  input  logic [DATAWIDTH_IN_A-1:0] s_axis_a_tdata,
  input  logic                      s_axis_b_tvalid,
  output logic                      s_axis_b_tready,
  input  logic [DATAWIDTH_IN_B-1:0] s_axis_b_tdata,
  output logic                      m_axis_a_tvalid,
  output logic [DATAWIDTH_IN_A-1:0] m_axis_a_tdata,
  output logic                      m_axis_b_tvalid,
  output logic [DATAWIDTH_IN_B-1:0] m_axis_b_tdata,
  input  logic                      m_axis_tready
`ifdef JOIN_STATS_EN
  ,
  output logic [31:0]               pair_count,
  output logic [$clog2(DEPTH):0]    skew_max
`endif
);

  localparam int CW = ptr_w(DEPTH) + 1;

  logic [DATAWIDTH_IN_A-1:0] head_a, slot_a_q, slot_a_d;
  logic [DATAWIDTH_IN_B-1:0] head_b, slot_b_q, slot_b_d;
  logic [CW-1:0]             cnt_a, cnt_b;
  logic                      both_avail, load;
  slot_state_e               state_q, state_d;

  join_fifo #(.WIDTH(DATAWIDTH_IN_A), .DEPTH(DEPTH)) u_fifo_a (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (s_axis_a_tvalid),
    .pop_i   (load),
    .wdata_i (s_axis_a_tdata),
    .rdata_o (head_a),
    .ready_o (s_axis_a_tready),
    .count_o (cnt_a)
  );

  join_fifo #(.WIDTH(DATAWIDTH_IN_B), .DEPTH(DEPTH)) u_fifo_b (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (s_axis_b_tvalid),
    .pop_i   (load),
    .wdata_i (s_axis_b_tdata),
    .rdata_o (head_b),
    .ready_o (s_axis_b_tready),
    .count_o (cnt_b)
  );

  assign both_avail = (cnt_a != '0) && (cnt_b != '0);

  // Both heads leave together, so A and B can never drift out of order.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    case (state_q)
      IDLE: begin
        if (both_avail) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (m_axis_tready) begin
          if (both_avail) load = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      slot_a_d = head_a;
      slot_b_d = head_b;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      slot_a_q <= '0;
      slot_b_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
    end
  end

  assign m_axis_a_tvalid = (state_q == FULL);
  assign m_axis_b_tvalid = (state_q == FULL);
  assign m_axis_a_tdata  = slot_a_q;
  assign m_axis_b_tdata  = slot_b_q;

`ifdef JOIN_STATS_EN
  logic [31:0]   pair_cnt_q, pair_cnt_d;
  logic [CW-1:0] skew_max_q, skew_max_d, skew_now;

  always_comb begin
    skew_now   = (cnt_a >= cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
    pair_cnt_d = load ? pair_cnt_q + 32'd1 : pair_cnt_q;
    skew_max_d = (skew_now > skew_max_q) ? skew_now : skew_max_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pair_cnt_q <= '0;
      skew_max_q <= '0;
    end else begin
      pair_cnt_q <= pair_cnt_d;
      skew_max_q <= skew_max_d;
    end
  end

  assign pair_count = pair_cnt_q;
  assign skew_max   = skew_max_q;
`endif

endmodule
